booth_r4_mult: RTL and testbench
================================

Name: booth_r4_mult

Overview:
- Iterative, parametrised radix-4 Booth multiplier for the ALU multiply path.
- Replaces the 32-bit radix-2 unit. Changes from that unit:
  - WIDTH is configurable.
  - Selectable signed/unsigned mode.
  - Two multiplier bits retired per cycle, so latency is about half.
  - Explicit start/busy/ready handshake.
  - Overflow exception in both modes.

Parameters:
- WIDTH, 32, operand and result width. Must be even and ≥4.

Ports:
- clock  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a multiply. Sampled on the rising edge; accepted only when busy=0.
- is_signed  input  1  1 = two's-complement operands, 0 = unsigned. Latched with the operands.
- A_in  input  WIDTH  multiplicand. Latched on an accepted start.
- B_in  input  WIDTH  multiplier. Latched on an accepted start.
- out  output  WIDTH  low WIDTH bits of the product.
- busy  output  1  an operation is in progress.
- ready  output  1  one-cycle pulse: result valid.
- exception  output  1  product does not fit WIDTH bits. Qualified by ready, held with out.

Behaviour:
- Reset (async, reset_n=0): state IDLE. out=0, busy=0, ready=0, exception=0. Operand, product and counter registers cleared. The operation in flight is discarded, and no ready follows the reset.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - DONE: busy=0, ready=1 for exactly one cycle, then IDLE.
- Accepted start (IDLE or DONE, start=1 at an edge):
  - Latch A_in, B_in and is_signed.
  - Extend both operands to WIDTH+2 bits: sign-extend when is_signed=1, zero-extend otherwise.
  - Load the product register, 2*WIDTH+5 bits: {zeros, extended B, 1'b0}.
  - Load the counter with N = WIDTH/2+1. Go to RUN.
- RUN, each edge:
  - Recode the product register's low 3 bits {b[i+1], b[i], b[i-1]} to a digit in {-2,-1,0,+1,+2}.
  - Add digit × extended A into the upper part.
  - Arithmetic-shift the register right by 2 and decrement the counter.
  - The edge that takes the counter to 0 enters DONE.
  - The digit is applied in the same edge that it is recoded.
- Latency: start accepted at edge E gives ready=1 in the cycle after edge E+N. For WIDTH=32 that is edge E+17.
- out and exception update on entry to DONE. They hold until the next DONE or reset; an accepted start does not clear them.
- exception, when is_signed=1: set if the upper WIDTH bits of the 2*WIDTH-bit product differ from the sign-extension of out[WIDTH-1].
- exception, when is_signed=0: set if the upper WIDTH bits are nonzero.
- start while busy=1: ignored. No effect on operands, counter or the result in flight.
- start in DONE: accepted. ready still pulses for the finishing result, and the next state is RUN.
- Zero operands: normal full latency, with no early termination.
- Most-negative × -1 (signed): out = most-negative value, exception=1.

Optional Feature:
- Macro: BOOTH_R4_MULT_HI_OUT_EN.
- Defined:
  - Extra port out_hi, output, WIDTH: upper WIDTH bits of the 2*WIDTH-bit product, signed or unsigned per the latched mode.
  - out_hi updates and holds with out; reset value 0.
- Undefined:
  - Port absent. Only the bits needed for the exception compare are kept.
  - Behaviour is otherwise identical.

Test Plan:
1. WIDTH=32, signed. Start with A=7, B=-3 (0xFFFFFFFD) → busy=1 for 17 cycles, then ready for one cycle with out=0xFFFFFFEB (-21) and exception=0.
2. WIDTH=32, signed. A=0x80000000, B=0xFFFFFFFF → out=0x80000000, exception=1. With HI_OUT_EN: out_hi=0x00000000.
3. WIDTH=32, unsigned. A=0xFFFFFFFF, B=2 → out=0xFFFFFFFE, exception=1. With HI_OUT_EN: out_hi=0x00000001.
4. WIDTH=32. Start with A=5, B=6; pulse start with A=9, B=9 at cycle 5 → second start ignored; result out=30, exception=0 at cycle 17. Then restart on the DONE cycle with A=9, B=9 → out=81, 17 cycles later.
5. Start with A=1000, B=1000; drop reset_n at cycle 8 → immediately out=0, busy=0, ready=0. No ready pulse for the next 20 cycles.
6. WIDTH=8, signed. A=-128, B=-128 → ready after 5 cycles, out=0x00, exception=1. Unsigned A=15, B=17 → out=0xFF, exception=0.

Source files
------------

// File: rtl/booth_r4_mult.sv
// Iterative radix-4 Booth multiplier, signed/unsigned, with start/busy/ready handshake.
// Define BOOTH_R4_MULT_HI_OUT_EN to expose the upper product half on out_hi.
module booth_r4_mult #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             ready,
`ifdef BOOTH_R4_MULT_HI_OUT_EN
    output logic [WIDTH-1:0] out_hi,
`endif
    output logic             exception
);

    localparam int EW = WIDTH + 2;          // extended operand width
    localparam int PW = 2 * WIDTH + 5;      // product register width
    localparam int SW = WIDTH + 4;          // adder width (room for +/-2A)
    localparam int N  = WIDTH / 2 + 1;      // Booth digits per operation
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [EW-1:0]     a_q, a_d;
    logic [PW-1:0]     p_q, p_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sgn_q, sgn_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              exc_q, exc_d;
`ifdef BOOTH_R4_MULT_HI_OUT_EN
    logic [WIDTH-1:0]  hi_q, hi_d;
`endif

    logic [SW-1:0]        a_sx, up_sx, addend, sum;
    logic [SW+WIDTH+2:0]  wide;
    logic [PW-1:0]        p_step;
    logic [2*WIDTH-1:0]   prod;
    logic                 exc_step;
    logic                 accept;
    logic [EW-1:0]        a_ext, b_ext;

    // One Booth step: recode the low 3 bits, add digit*A into the upper field, shift by 2.
    always_comb begin
        a_sx  = {{2{a_q[EW-1]}}, a_q};
        up_sx = {{2{p_q[PW-1]}}, p_q[PW-1:WIDTH+3]};
        case (p_q[2:0])
            3'b001, 3'b010: addend = a_sx;
            3'b011:         addend = a_sx << 1;
            3'b100:         addend = -(a_sx << 1);
            3'b101, 3'b110: addend = -a_sx;
            default:        addend = '0;
        endcase
        sum    = up_sx + addend;
        wide   = {sum, p_q[WIDTH+2:0]};
        p_step = PW'(wide >> 2);
        // After the last step the full product sits just above the guard bit.
        prod   = p_step[2*WIDTH:1];
        if (sgn_q)
            exc_step = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
        else
            exc_step = |prod[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        a_ext = is_signed ? {{2{A_in[WIDTH-1]}}, A_in} : {2'b00, A_in};
        b_ext = is_signed ? {{2{B_in[WIDTH-1]}}, B_in} : {2'b00, B_in};
    end

    assign accept = start && (state_q != S_RUN);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        out_d   = out_q;
        exc_d   = exc_q;
`ifdef BOOTH_R4_MULT_HI_OUT_EN
        hi_d    = hi_q;
`endif
        case (state_q)
            S_RUN: begin
                p_d   = p_step;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    out_d   = prod[WIDTH-1:0];
                    exc_d   = exc_step;
`ifdef BOOTH_R4_MULT_HI_OUT_EN
                    hi_d    = prod[2*WIDTH-1:WIDTH];
`endif
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // A start in DONE overrides the return to IDLE; results stay held.
        if (accept) begin
            state_d = S_RUN;
            a_d     = a_ext;
            p_d     = {{(WIDTH+2){1'b0}}, b_ext, 1'b0};
            cnt_d   = CW'(N);
            sgn_d   = is_signed;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            out_q   <= '0;
            exc_q   <= 1'b0;
`ifdef BOOTH_R4_MULT_HI_OUT_EN
            hi_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            out_q   <= out_d;
            exc_q   <= exc_d;
`ifdef BOOTH_R4_MULT_HI_OUT_EN
            hi_q    <= hi_d;
`endif
        end
    end

    assign out       = out_q;
    assign exception = exc_q;
    assign busy      = (state_q == S_RUN);
    assign ready     = (state_q == S_DONE);
`ifdef BOOTH_R4_MULT_HI_OUT_EN
    assign out_hi    = hi_q;
`endif

endmodule

// File: tb/tb_booth_r4_mult.sv
// Scoreboard bench for booth_r4_mult: 32-bit and 8-bit instances checked against plain arithmetic.
module tb_booth_r4_mult;

    localparam int W  = 32;
    localparam int N  = W / 2 + 1;
    localparam int W8 = 8;
    localparam int N8 = W8 / 2 + 1;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0, is_signed = 1'b0;
    logic [31:0] A_in = '0, B_in = '0;
    logic [31:0] out;
    logic        busy, ready, exception;
`ifdef BOOTH_R4_MULT_HI_OUT_EN
    logic [31:0] out_hi;
    logic [7:0]  out_hi8;
`endif
    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [7:0]  out8;
    logic        busy8, ready8, exc8;

    booth_r4_mult #(.WIDTH(W)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .is_signed(is_signed),
        .A_in(A_in), .B_in(B_in), .out(out), .busy(busy), .ready(ready),
`ifdef BOOTH_R4_MULT_HI_OUT_EN
        .out_hi(out_hi),
`endif
        .exception(exception));

    booth_r4_mult #(.WIDTH(W8)) dut8 (
        .clock(clock), .reset_n(reset_n), .start(start8), .is_signed(sgn8),
        .A_in(a8), .B_in(b8), .out(out8), .busy(busy8), .ready(ready8),
`ifdef BOOTH_R4_MULT_HI_OUT_EN
        .out_hi(out_hi8),
`endif
        .exception(exc8));

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] prod;
        logic        exc;
        int          due;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    int   cyc = 0;
    int   n_pass = 0, n_tot = 0;
    int   last32 = -1000, last8 = -1000;
    bit   mon_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_tot = n_tot + 1;
        if (act === expv) n_pass = n_pass + 1;
        else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
    endtask

    task automatic fail_now(input string nm);
        n_tot = n_tot + 1;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference: exact mathematical product and range test.
    function automatic void ref32(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [63:0] p, output logic e);
        longint sp;
        if (s) begin
            sp = longint'(signed'(a)) * longint'(signed'(b));
            p  = sp;
            e  = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
        end else begin
            p = {32'b0, a} * {32'b0, b};
            e = (p > 64'h0000_0000_FFFF_FFFF);
        end
    endfunction

    function automatic void ref8(input logic [7:0] a, input logic [7:0] b, input logic s,
                                 output logic [63:0] p, output logic e);
        int sp;
        if (s) begin
            sp = int'(signed'(a)) * int'(signed'(b));
            e  = (sp > 127) || (sp < -128);
        end else begin
            sp = int'({24'b0, a}) * int'({24'b0, b});
            e  = (sp > 255);
        end
        p = 64'(sp);
    endfunction

    // A start is taken only if the unit is not mid-operation at that edge.
    task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        int   x;
        A_in = a; B_in = b; is_signed = s; start = 1'b1;
        @(posedge clock); #1;
        x = cyc;
        start = 1'b0;
        if (x > last32 + N) begin
            ref32(a, b, s, e.prod, e.exc);
            e.due = x + N;
            q32.push_back(e);
            last32 = x;
        end
    endtask

    task automatic start8t(input logic [7:0] a, input logic [7:0] b, input logic s);
        exp_t e;
        int   x;
        a8 = a; b8 = b; sgn8 = s; start8 = 1'b1;
        @(posedge clock); #1;
        x = cyc;
        start8 = 1'b0;
        if (x > last8 + N8) begin
            ref8(a, b, s, e.prod, e.exc);
            e.due = x + N8;
            q8.push_back(e);
            last8 = x;
        end
    endtask

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h7FFF_FFFF;
            4: return 32'(int'($urandom_range(0, 200)) - 100);
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clock) begin : mon32
        exp_t e;
        if (mon_en) begin
            chk("busy32", {63'b0, busy}, {63'b0, (cyc >= last32) && (cyc < last32 + N)});
            if (ready) begin
                if (q32.size() == 0) fail_now("ready32_unexpected");
                else begin
                    e = q32.pop_front();
                    chk("latency32", 64'(cyc), 64'(e.due));
                    chk("out32", {32'b0, out}, {32'b0, e.prod[31:0]});
                    chk("exc32", {63'b0, exception}, {63'b0, e.exc});
`ifdef BOOTH_R4_MULT_HI_OUT_EN
                    chk("out_hi32", {32'b0, out_hi}, {32'b0, e.prod[63:32]});
`endif
                end
            end else if (q32.size() != 0 && cyc > q32[0].due) begin
                fail_now("ready32_missing");
                void'(q32.pop_front());
            end
        end
    end

    always @(negedge clock) begin : mon8
        exp_t e;
        if (mon_en) begin
            chk("busy8", {63'b0, busy8}, {63'b0, (cyc >= last8) && (cyc < last8 + N8)});
            if (ready8) begin
                if (q8.size() == 0) fail_now("ready8_unexpected");
                else begin
                    e = q8.pop_front();
                    chk("latency8", 64'(cyc), 64'(e.due));
                    chk("out8", {56'b0, out8}, {56'b0, e.prod[7:0]});
                    chk("exc8", {63'b0, exc8}, {63'b0, e.exc});
`ifdef BOOTH_R4_MULT_HI_OUT_EN
                    chk("out_hi8", {56'b0, out_hi8}, {56'b0, e.prod[15:8]});
`endif
                end
            end else if (q8.size() != 0 && cyc > q8[0].due) begin
                fail_now("ready8_missing");
                void'(q8.pop_front());
            end
        end
    end

    initial begin
        int e0;
        repeat (2) @(negedge clock);
        chk("rst_out", {32'b0, out}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_ready", {63'b0, ready}, 64'd0);
        chk("rst_exc", {63'b0, exception}, 64'd0);
        chk("rst_out8", {56'b0, out8}, 64'd0);
        reset_n = 1'b1;
        #1 mon_en = 1'b1;
        @(negedge clock);

        start32(32'd7, 32'hFFFF_FFFD, 1'b1);
        repeat (N + 3) @(negedge clock);
        start32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        repeat (N + 3) @(negedge clock);
        start32(32'hFFFF_FFFF, 32'd2, 1'b0);
        repeat (N + 3) @(negedge clock);

        // Ignored start while busy, then a restart on the DONE cycle.
        start32(32'd5, 32'd6, 1'b0);
        e0 = last32;
        repeat (4) @(negedge clock);
        start32(32'd9, 32'd9, 1'b0);
        while (cyc < e0 + N) @(negedge clock);
        start32(32'd9, 32'd9, 1'b0);
        repeat (N + 3) @(negedge clock);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, N + 4)) @(negedge clock);
            start32(pick32(), pick32(), 1'($urandom_range(0, 1)));
        end
        repeat (N + 3) @(negedge clock);

        // Reset in flight: outputs clear at once and no ready follows.
        start32(32'd1000, 32'd1000, 1'b0);
        repeat (7) @(negedge clock);
        @(posedge clock); #2;
        mon_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_out", {32'b0, out}, 64'd0);
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_ready", {63'b0, ready}, 64'd0);
        chk("arst_exc", {63'b0, exception}, 64'd0);
        q32.delete();
        q8.delete();
        last32 = -1000;
        last8 = -1000;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        #1 mon_en = 1'b1;
        repeat (20) @(negedge clock);

        start8t(8'h80, 8'h80, 1'b1);
        repeat (N8 + 3) @(negedge clock);
        start8t(8'd15, 8'd17, 1'b0);
        repeat (N8 + 3) @(negedge clock);
        start8t(8'h80, 8'hFF, 1'b1);
        repeat (N8 + 3) @(negedge clock);
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, N8 + 3)) @(negedge clock);
            start8t(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 60 && (q32.size() != 0 || q8.size() != 0); i++)
            @(negedge clock);
        if (q32.size() != 0 || q8.size() != 0) fail_now("drain_timeout");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
